cycle_count_reader: RTL and testbench
=====================================

Name: cycle_count_reader

Overview:
- Consumer end of the cycle-counter interface.
- Watches the free-running start flag and 16-bit cycle count, and extends the count past 16-bit wrap-around.
- Captures elapsed run time when the core halts.
- Serves coherent elapsed-cycle snapshots to the CPU/debug side over a valid/ack read handshake.

Parameters:
- CNT_W, 16, width of incoming cycle count.
- EXT_W, 16, width of wrap-extension counter; elapsed width OUT_W = CNT_W+EXT_W (32).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- prog_start  in  1  start flag from cycle counter; level, stays high once set.
- cyc_cnt  in  CNT_W  cycle count from counter; +1 per clock while prog_start high.
- halt  in  1  core halt indication, single-cycle or level.
- rd_req  in  1  request snapshot of elapsed cycles.
- rd_ack  in  1  consumer has taken rd_data.
- rd_valid  out  1  rd_data holds an unconsumed snapshot.
- rd_data  out  OUT_W  snapshot of elapsed cycles.
- rd_overrun  out  1  sticky: rd_req dropped because a snapshot was pending.
- run_cycles  out  OUT_W  final elapsed cycles, frozen at halt.
- running  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Reset (async, immediate): state IDLE; base, prev_cnt, ext, run_cycles, rd_data = 0; rd_valid, rd_overrun, running, done = 0.
- Reset mid-operation aborts everything; a fresh prog_start high is needed to re-enter RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on first clock with prog_start=1. That edge: base <= cyc_cnt, prev_cnt <= cyc_cnt, ext <= 0.
  - halt in IDLE is ignored; halt in the same cycle as the IDLE->RUN entry is ignored.
  - RUN -> DONE on clock with halt=1. That edge: run_cycles <= elapsed.
  - DONE is terminal until reset; prog_start and halt are ignored.
- Wrap detection (RUN only):
  - wrap = (cyc_cnt < prev_cnt), unsigned compare.
  - Each RUN clock: prev_cnt <= cyc_cnt; if wrap, ext <= ext+1 (modulo 2^EXT_W).
  - Only one wrap is tracked per cycle.
- Elapsed computation (combinational, coherent within the cycle):
  - ext_now = ext + wrap.
  - elapsed = {ext_now, cyc_cnt} - {0, base}, modulo 2^OUT_W.
  - Snapshot value: 0 in IDLE, elapsed in RUN, run_cycles in DONE.
- Read handshake:
  - rd_req with rd_valid=0: rd_data <= snapshot, rd_valid <= 1 next edge (1-cycle latency).
  - rd_ack with rd_valid=1 and no rd_req: rd_valid <= 0; rd_data holds its last value.
  - rd_req and rd_ack both high with rd_valid=1: old snapshot consumed, new snapshot loaded, rd_valid stays 1, no overrun.
  - rd_req with rd_valid=1 and rd_ack=0: request dropped, rd_data unchanged, rd_overrun <= 1 (sticky until reset).
  - rd_ack with rd_valid=0: ignored.
  - rd_data is stable while rd_valid=1 and no accepted new request.
- running and done are registered decodes of the state.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-clock -> all outputs 0 at once; state IDLE; prog_start/halt held low for 10 clocks -> outputs stay 0.
2. Basic run: prog_start rises with cyc_cnt=0, counter increments, halt pulsed when cyc_cnt=100 -> next edge done=1, running=0, run_cycles=100; later halt pulses leave run_cycles=100.
3. Wrap: start with cyc_cnt=0xFFF0, counter wraps, halt at cyc_cnt=0x0010 -> run_cycles=0x00000020; an rd_req on the wrap cycle (cyc_cnt=0x0000) -> rd_data=0x00000010 with no glitch.
4. Read hold/overrun: in RUN, rd_req when elapsed=5 -> next edge rd_valid=1, rd_data=5; no ack for 3 clocks plus a second rd_req -> rd_data stays 5, rd_overrun=1; rd_ack -> rd_valid=0, rd_overrun stays 1.
5. Simultaneous req+ack: rd_valid=1, rd_data=7; rd_req+rd_ack when elapsed=12 -> rd_data=12, rd_valid stays 1, rd_overrun stays 0.
6. Edge cases:
   - Reset mid-RUN (elapsed=50), release, prog_start held high -> re-enter RUN with base=current cyc_cnt, elapsed restarts at 0.
   - halt together with first prog_start -> RUN, not DONE.

Source files
------------

// File: rtl/cycle_count_reader.sv
// Consumer end of the cycle-counter link: extends the 16-bit count past wrap-around,
// freezes run time at halt, and serves elapsed-cycle snapshots over a valid/ack read port.
module cycle_count_reader #(
  parameter int CNT_W = 16,
  parameter int EXT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_start,
  input  logic [CNT_W-1:0]       cyc_cnt,
  input  logic                   halt,
  input  logic                   rd_req,
  input  logic                   rd_ack,
  output logic                   rd_valid,
  output logic [CNT_W+EXT_W-1:0] rd_data,
  output logic                   rd_overrun,
  output logic [CNT_W+EXT_W-1:0] run_cycles,
  output logic                   running,
  output logic                   done
);

  localparam int OUT_W = CNT_W + EXT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_base;
  logic [CNT_W-1:0] r_prev_cnt;
  logic [EXT_W-1:0] r_ext;

  logic             w_wrap;
  logic [EXT_W-1:0] w_ext_now;
  logic [OUT_W-1:0] w_elapsed;
  logic [OUT_W-1:0] w_snapshot;
  logic             w_take;

  // The wrap seen this cycle is folded in combinationally so a snapshot taken
  // on the wrap cycle itself is already coherent.
  assign w_wrap    = (r_state == S_RUN) && (cyc_cnt < r_prev_cnt);
  assign w_ext_now = r_ext + EXT_W'(w_wrap);
  assign w_elapsed = {w_ext_now, cyc_cnt} - {{EXT_W{1'b0}}, r_base};

  always_comb begin
    w_snapshot = '0;
    case (r_state)
      S_RUN:   w_snapshot = w_elapsed;
      S_DONE:  w_snapshot = run_cycles;
      default: w_snapshot = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_prev_cnt <= '0;
      r_ext      <= '0;
      run_cycles <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_start) begin
            r_state    <= S_RUN;
            r_base     <= cyc_cnt;
            r_prev_cnt <= cyc_cnt;
            r_ext      <= '0;
            running    <= 1'b1;
          end
        end
        S_RUN: begin
          r_prev_cnt <= cyc_cnt;
          r_ext      <= w_ext_now;
          if (halt) begin
            r_state    <= S_DONE;
            run_cycles <= w_elapsed;
            running    <= 1'b0;
            done       <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Read port: rd_valid/rd_data form a one-deep holding register. A request is
  // accepted when the slot is empty or is being acked in the same cycle; a
  // request against a full, un-acked slot is dropped and flagged as overrun.
  assign w_take = rd_req && (!rd_valid || rd_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        rd_data  <= w_snapshot;
        rd_valid <= 1'b1;
      end else if (rd_req) begin
        rd_overrun <= 1'b1;
      end else if (rd_ack && rd_valid) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cycle_count_reader.sv
// Bench for cycle_count_reader: directed scenarios then randomized runs, all checked
// against a model that counts clocks since run entry instead of decoding the count.
module tb_cycle_count_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_start = 1'b0;
  logic [15:0] cyc_cnt = '0;
  logic        halt = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_ack = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_overrun;
  logic [31:0] run_cycles;
  logic        running;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 running, 2 done; m_el = clocks since the entry edge.
  int          m_phase;
  int unsigned m_el;
  int unsigned m_rc;
  logic        m_v;
  logic [31:0] m_d;
  logic        m_ov;

  cycle_count_reader #(.CNT_W(16), .EXT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .cyc_cnt(cyc_cnt),
    .halt(halt), .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_overrun(rd_overrun), .run_cycles(run_cycles),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_rc = 0; m_v = 1'b0; m_d = '0; m_ov = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] snap;
    if (!rst_n) return;
    snap = (m_phase == 0) ? 32'd0 : (m_phase == 1) ? m_el : m_rc;
    if (rd_req && (!m_v || rd_ack)) begin
      m_d = snap; m_v = 1'b1;
    end else if (rd_req) begin
      m_ov = 1'b1;
    end else if (rd_ack && m_v) begin
      m_v = 1'b0;
    end
    if (m_phase == 0) begin
      if (prog_start) begin m_phase = 1; m_el = 1; end
    end else if (m_phase == 1) begin
      if (halt) begin m_rc = m_el; m_phase = 2; end
      else m_el = m_el + 1;
    end
  endtask

  task automatic check_all();
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_v});
    check("rd_data", rd_data, m_d);
    check("rd_overrun", {31'd0, rd_overrun}, {31'd0, m_ov});
    check("run_cycles", run_cycles, m_rc);
    check("running", {31'd0, running}, {31'd0, m_phase == 1});
    check("done", {31'd0, done}, {31'd0, m_phase == 2});
  endtask

  // One clock: model consumes the pre-edge inputs, the counter advances after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (prog_start) cyc_cnt = cyc_cnt + 16'd1;
    check_all();
  endtask

  task automatic do_reset(input int hold);
    halt = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int unsigned target);
    for (int i = 0; i < 2000 && !(m_phase == 1 && m_el == target); i++) step();
    check("run_to_timeout", m_el, target);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic run: start at 0, halt at count 100.
    cyc_cnt = 16'd0; prog_start = 1'b1;
    step();
    check("t2_running", {31'd0, running}, 32'd1);
    while (cyc_cnt != 16'd100 && m_el < 200) step();
    halt = 1'b1; step(); halt = 1'b0;
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_run_cycles", run_cycles, 32'd100);
    repeat (3) begin halt = 1'b1; step(); halt = 1'b0; step(); end
    check("t2_run_frozen", run_cycles, 32'd100);

    // Asynchronous reset mid-clock, inputs low for ten clocks.
    prog_start = 1'b0;
    do_reset(10);
    check("t1_run_cycles", run_cycles, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);

    // Wrap: start at 0xFFF0, snapshot on the wrap cycle, halt at 0x0010.
    do_reset(1);
    cyc_cnt = 16'hFFF0; prog_start = 1'b1;
    step();
    run_to(16);
    check("t3_cnt_zero", {16'd0, cyc_cnt}, 32'd0);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check("t3_wrap_snapshot", rd_data, 32'h10);
    run_to(32);
    halt = 1'b1; step(); halt = 1'b0;
    check("t3_run_cycles", run_cycles, 32'h20);

    // Hold and overrun.
    do_reset(1);
    cyc_cnt = 16'h1234; prog_start = 1'b1;
    step();
    run_to(5);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check("t4_data", rd_data, 32'd5);
    repeat (3) step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check("t4_hold", rd_data, 32'd5);
    check("t4_overrun", {31'd0, rd_overrun}, 32'd1);
    rd_ack = 1'b1; step(); rd_ack = 1'b0;
    check("t4_acked", {31'd0, rd_valid}, 32'd0);
    check("t4_overrun_sticky", {31'd0, rd_overrun}, 32'd1);

    // Simultaneous request and ack.
    do_reset(1);
    cyc_cnt = 16'd500; prog_start = 1'b1;
    step();
    run_to(7);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check("t5_first", rd_data, 32'd7);
    run_to(12);
    rd_req = 1'b1; rd_ack = 1'b1; step(); rd_req = 1'b0; rd_ack = 1'b0;
    check("t5_data", rd_data, 32'd12);
    check("t5_valid", {31'd0, rd_valid}, 32'd1);
    check("t5_no_overrun", {31'd0, rd_overrun}, 32'd0);

    // Reset mid-run with prog_start held high: run restarts from the new base.
    do_reset(1);
    cyc_cnt = 16'd9000; prog_start = 1'b1;
    step();
    run_to(50);
    do_reset(2);
    step();
    check("t6_reentry", {31'd0, running}, 32'd1);
    run_to(3);
    halt = 1'b1; step(); halt = 1'b0;
    check("t6_restart_cycles", run_cycles, 32'd3);

    // Halt together with the first prog_start is ignored.
    prog_start = 1'b0;
    do_reset(2);
    halt = 1'b1; step();
    prog_start = 1'b1; step(); halt = 1'b0;
    check("t6_halt_entry_running", {31'd0, running}, 32'd1);
    check("t6_halt_entry_done", {31'd0, done}, 32'd0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int unsigned len;
      prog_start = 1'b0;
      do_reset($urandom_range(1, 3));
      cyc_cnt = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                            : 16'($urandom_range(0, 16'hFFFF));
      repeat ($urandom_range(0, 5)) begin
        halt = $urandom_range(0, 1) == 1;
        rd_req = $urandom_range(0, 2) == 0;
        rd_ack = $urandom_range(0, 1) == 1;
        step();
      end
      halt = 1'b0;
      prog_start = 1'b1;
      len = $urandom_range(10, 400);
      for (int unsigned i = 0; i < len; i++) begin
        halt = (i == len - 1);
        rd_req = $urandom_range(0, 2) == 0;
        rd_ack = $urandom_range(0, 1) == 1;
        step();
      end
      repeat ($urandom_range(2, 10)) begin
        halt = $urandom_range(0, 1) == 1;
        rd_req = $urandom_range(0, 2) == 0;
        rd_ack = $urandom_range(0, 1) == 1;
        step();
      end
      halt = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
